// File: rtl/serial_byte_rx_if.sv
// Serial receiver bus: sample strobe, serial line and consumer handshake.
interface serial_byte_rx_if #(
    parameter int DATA_W = 8
);
    logic              bit_en;
    logic              s_in;
    logic              data_ack;
    logic [DATA_W-1:0] p_out;
    logic              data_valid;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    // Receiver side: consumes the line and strobe, produces the word and flags.
    modport slave (
        input  bit_en, s_in, data_ack,
        output p_out, data_valid, frame_err, overrun, busy
    );

    // Driver/consumer side.
    modport master (
        output bit_en, s_in, data_ack,
        input  p_out, data_valid, frame_err, overrun, busy
    );
endinterface

// File: rtl/serial_byte_rx.sv
// Framed serial-to-parallel receiver: start bit (double sampled), DATA_W data
// bits MSB first, stop bit. Completed words are offered with a valid/ack
// handshake; bad stop bits pulse frame_err, words lost to an unconsumed
// predecessor set the sticky overrun flag.
module serial_byte_rx #(
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_byte_rx_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        START_CHK,
        DATA,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] p_out_q, p_out_d;
    logic              data_valid_q, data_valid_d;
    logic              overrun_q, overrun_d;
    logic              frame_err_q, frame_err_d;

    // Next-state: framing FSM advances only on strobes; the ack path runs every cycle.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        p_out_d      = p_out_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;
        frame_err_d  = 1'b0;

        if (bus.data_ack && data_valid_q) begin
            data_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end

        if (bus.bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!bus.s_in) state_d = START_CHK;
                end
                START_CHK: begin
                    // Second low sample confirms the start bit; a high one is a glitch.
                    if (!bus.s_in) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    shift_d = (shift_q << 1) | DATA_W'(bus.s_in);
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) state_d = STOP;
                end
                STOP: begin
                    if (bus.s_in) begin
                        // A same-edge ack frees the holding register for the new word.
                        if (!data_valid_q || bus.data_ack) begin
                            p_out_d      = shift_q;
                            data_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            p_out_q      <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            p_out_q      <= p_out_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.p_out      = p_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_serial_byte_rx.sv
// Bench for serial_byte_rx: a frame-level model decodes the strobed sample
// stream; every cycle the DUT is compared against it, and literal values pin
// the key results.
module tb_serial_byte_rx;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_byte_rx_if #(.DATA_W(DATA_W)) bus ();

    serial_byte_rx #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: samples of the frame in progress, plus output registers.
    logic       mq[$];
    logic [7:0] m_pout;
    logic       m_dv, m_ov, m_fe;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pout = '0;
        m_dv   = 1'b0;
        m_ov   = 1'b0;
        m_fe   = 1'b0;
    endtask

    // Apply one clock edge's worth of inputs to the model.
    task automatic model_edge(input logic be, input logic s, input logic ack);
        logic old_dv;
        logic n_fe;
        int   word;
        old_dv = m_dv;
        n_fe   = 1'b0;
        if (ack && old_dv) begin
            m_dv = 1'b0;
            m_ov = 1'b0;
        end
        if (be) begin
            if (mq.size() == 0) begin
                if (!s) mq.push_back(s);
            end else if (mq.size() == 1 && s) begin
                mq.delete();
            end else begin
                mq.push_back(s);
                if (mq.size() == DATA_W + 3) begin
                    word = 0;
                    for (int i = 2; i < DATA_W + 2; i++) word = word * 2 + int'(mq[i]);
                    if (s) begin
                        if (!old_dv || ack) begin
                            m_pout = word[7:0];
                            m_dv   = 1'b1;
                        end else begin
                            m_ov = 1'b1;
                        end
                    end else begin
                        n_fe = 1'b1;
                    end
                    mq.delete();
                end
            end
        end
        m_fe = n_fe;
    endtask

    task automatic compare_model();
        chk("p_out",      32'(bus.p_out),      32'(m_pout));
        chk("data_valid", 32'(bus.data_valid), 32'(m_dv));
        chk("overrun",    32'(bus.overrun),    32'(m_ov));
        chk("frame_err",  32'(bus.frame_err),  32'(m_fe));
        chk("busy",       32'(bus.busy),       32'(mq.size() != 0));
    endtask

    // One clock: drive inputs, advance model, check outputs 1 time unit after the edge.
    task automatic step(input logic be, input logic s, input logic ack);
        bus.bit_en   = be;
        bus.s_in     = s;
        bus.data_ack = ack;
        model_edge(be, s, ack);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic strobe(input logic s, input int gap, input logic ack);
        for (int g = 0; g < gap; g++) step(1'b0, s, 1'b0);
        step(1'b1, s, ack);
    endtask

    task automatic send_frame(input logic [7:0] w, input logic stop, input int gap, input logic ack_stop);
        strobe(1'b0, gap, 1'b0);
        strobe(1'b0, gap, 1'b0);
        for (int i = DATA_W - 1; i >= 0; i--) strobe(w[i], gap, 1'b0);
        strobe(stop, gap, ack_stop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        bus.bit_en   = 1'b0;
        bus.s_in     = 1'b1;
        bus.data_ack = 1'b0;
        model_reset();
        #12;
        chk("reset p_out", 32'(bus.p_out), 32'h0);
        chk("reset data_valid", 32'(bus.data_valid), 32'h0);
        chk("reset busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        #1;
        idle(2);

        // Reset mid-DATA after 3 data bits.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("busy mid-frame", 32'(bus.busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async rst busy", 32'(bus.busy), 32'h0);
        chk("async rst valid", 32'(bus.data_valid), 32'h0);
        chk("async rst overrun", 32'(bus.overrun), 32'h0);
        chk("async rst frame_err", 32'(bus.frame_err), 32'h0);
        chk("async rst p_out", 32'(bus.p_out), 32'h0);
        #2 rst = 1'b0;
        @(negedge clk);
        idle(1);
        send_frame(8'h55, 1'b1, 0, 1'b0);
        chk("post-reset p_out", 32'(bus.p_out), 32'h55);
        chk("post-reset valid", 32'(bus.data_valid), 32'h1);
        step(1'b1, 1'b1, 1'b1);
        idle(1);

        // Good frame 0xA5 at full rate.
        send_frame(8'hA5, 1'b1, 0, 1'b0);
        chk("A5 p_out", 32'(bus.p_out), 32'hA5);
        chk("A5 valid", 32'(bus.data_valid), 32'h1);
        chk("A5 busy", 32'(bus.busy), 32'h0);
        idle(1);
        chk("A5 busy next", 32'(bus.busy), 32'h0);
        step(1'b1, 1'b1, 1'b1);
        chk("A5 acked", 32'(bus.data_valid), 32'h0);
        idle(1);

        // Framing error.
        send_frame(8'h3C, 1'b0, 0, 1'b0);
        chk("fe pulse", 32'(bus.frame_err), 32'h1);
        chk("fe valid", 32'(bus.data_valid), 32'h0);
        chk("fe p_out kept", 32'(bus.p_out), 32'hA5);
        idle(1);
        chk("fe cleared", 32'(bus.frame_err), 32'h0);

        // Overrun.
        send_frame(8'h11, 1'b1, 0, 1'b0);
        idle(1);
        send_frame(8'h22, 1'b1, 0, 1'b0);
        chk("ovr p_out", 32'(bus.p_out), 32'h11);
        chk("ovr flag", 32'(bus.overrun), 32'h1);
        idle(2);
        chk("ovr sticky", 32'(bus.overrun), 32'h1);
        step(1'b1, 1'b1, 1'b1);
        chk("ovr ack valid", 32'(bus.data_valid), 32'h0);
        chk("ovr ack clear", 32'(bus.overrun), 32'h0);
        idle(1);

        // Ack coinciding with a good stop.
        send_frame(8'h11, 1'b1, 0, 1'b0);
        idle(1);
        send_frame(8'h22, 1'b1, 0, 1'b1);
        chk("simul p_out", 32'(bus.p_out), 32'h22);
        chk("simul valid", 32'(bus.data_valid), 32'h1);
        chk("simul overrun", 32'(bus.overrun), 32'h0);
        step(1'b1, 1'b1, 1'b1);
        idle(1);

        // Strobe every 4th cycle, with frozen cycles in between.
        send_frame(8'h0F, 1'b1, 3, 1'b0);
        chk("gated p_out", 32'(bus.p_out), 32'h0F);
        chk("gated valid", 32'(bus.data_valid), 32'h1);
        step(1'b1, 1'b1, 1'b1);
        idle(1);

        // Single-strobe low glitch.
        step(1'b1, 1'b0, 1'b0);
        chk("glitch busy", 32'(bus.busy), 32'h1);
        step(1'b1, 1'b1, 1'b0);
        chk("glitch back idle", 32'(bus.busy), 32'h0);
        idle(2);
        chk("glitch no fe", 32'(bus.frame_err), 32'h0);
        chk("glitch no valid", 32'(bus.data_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
